ram_march_bist: RTL and testbench

- Initiator for one port of the team's true dual-port RAM (8-bit data, 5-bit address, active-high cs/wr/out_en).
- Runs a March C- self-test over the whole array and reports pass/fail with first-failure diagnostics.
- One instance per RAM port. It drives the cs/wr/out_en/address/write-data pins and consumes read-data.

---
 rtl/bist_pkg.sv | 33 +++
 rtl/march_addr_gen.sv | 46 ++++
 rtl/ram_march_bist.sv | 209 ++++++++++++++++++++
 tb/tb_ram_march_bist.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - March C- element tables, FSM states and background patterns
package bist_pkg;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_RWAIT = 3'd3,
    S_CMP   = 3'd4,
    S_DONE  = 3'd5
  } bist_state_t;

  // Bit i of each table describes element Mi.
  localparam logic [5:0] ELEM_UP     = 6'b100111;
  localparam logic [5:0] ELEM_HAS_RD = 6'b111110;
  localparam logic [5:0] ELEM_HAS_WR = 6'b011111;
  localparam logic [5:0] ELEM_RD_B1  = 6'b010100;
  localparam logic [5:0] ELEM_WR_B1  = 6'b001010;

  // Backgrounds are a single bit replicated across the data width.
  localparam logic BG_B0 = 1'b0;
  localparam logic BG_B1 = 1'b1;

endpackage

// File: rtl/march_addr_gen.sv
// rtl/march_addr_gen.sv - loadable up/down address counter with first/last flags
module march_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_up,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              up_q, up_d;

  always_comb begin
    addr_d = addr_q;
    up_d   = up_q;
    if (load) begin
      up_d   = load_up;
      addr_d = load_up ? '0 : ADDR_MAX;
    end else if (step) begin
      addr_d = up_q ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      up_q   <= 1'b1;
    end else begin
      addr_q <= addr_d;
      up_q   <= up_d;
    end
  end

  assign addr  = addr_q;
  assign first = up_q ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign last  = up_q ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/ram_march_bist.sv
// rtl/ram_march_bist.sv - March C- BIST initiator for one RAM port
// BIST_ERR_CNT_EN: count every mismatch and run to completion instead of aborting.
module ram_march_bist
  import bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic              ram_cs,
  output logic              ram_wr,
  output logic              ram_out_en,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_d_in,
  input  logic [DATA_W-1:0] ram_d_out
`ifdef BIST_ERR_CNT_EN
  ,
  output logic [ADDR_W+2:0] err_cnt
`endif
);

  localparam logic [DATA_W-1:0] PAT_B0     = {DATA_W{BG_B0}};
  localparam logic [DATA_W-1:0] PAT_B1     = {DATA_W{BG_B1}};
  localparam logic [1:0]        RWAIT_LAST = 2'(RD_LAT - 2);

  bist_state_t       state_q, state_d;
  march_elem_t       elem_q, elem_d, elem_next;
  logic [1:0]        cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              fail_seen_q, fail_seen_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0] fail_act_q, fail_act_d;
`ifdef BIST_ERR_CNT_EN
  localparam logic [ADDR_W+2:0] ERR_MAX = '1;
  localparam logic [ADDR_W+2:0] ERR_ONE = {{(ADDR_W+2){1'b0}}, 1'b1};
  logic [ADDR_W+2:0] err_cnt_q, err_cnt_d;
`endif

  logic              ag_load, ag_load_up, ag_step, ag_last, ag_first_unused;
  logic [ADDR_W-1:0] ag_addr;
  logic [DATA_W-1:0] rd_exp, wr_pat;
  logic              rd_mismatch, advance;

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ag_load),
    .load_up(ag_load_up),
    .step   (ag_step),
    .addr   (ag_addr),
    .first  (ag_first_unused),
    .last   (ag_last)
  );

  assign elem_next   = march_elem_t'(elem_q + 3'd1);
  assign rd_exp      = ELEM_RD_B1[elem_q] ? PAT_B1 : PAT_B0;
  assign wr_pat      = ELEM_WR_B1[elem_q] ? PAT_B1 : PAT_B0;
  assign rd_mismatch = (ram_d_out != rd_exp);

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    fail_seen_d = fail_seen_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
`ifdef BIST_ERR_CNT_EN
    err_cnt_d   = err_cnt_q;
`endif
    ag_load     = 1'b0;
    ag_load_up  = 1'b1;
    ag_step     = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WR;
          elem_d      = M0;
          ag_load     = 1'b1;
          ag_load_up  = ELEM_UP[M0];
          pass_d      = 1'b0;
          fail_seen_d = 1'b0;
          fail_elem_d = '0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
`ifdef BIST_ERR_CNT_EN
          err_cnt_d   = '0;
`endif
        end
      end
      S_WR: advance = 1'b1;
      S_RD: begin
        if (RD_LAT == 1) begin
          state_d = S_CMP;
        end else begin
          state_d = S_RWAIT;
          cnt_d   = 2'd0;
        end
      end
      S_RWAIT: begin
        if (cnt_q == RWAIT_LAST) state_d = S_CMP;
        else                     cnt_d   = cnt_q + 2'd1;
      end
      S_CMP: begin
        if (rd_mismatch && !fail_seen_q) begin
          fail_seen_d = 1'b1;
          fail_elem_d = elem_q;
          fail_addr_d = ag_addr;
          fail_exp_d  = rd_exp;
          fail_act_d  = ram_d_out;
        end
`ifdef BIST_ERR_CNT_EN
        if (rd_mismatch && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
        if (ELEM_HAS_WR[elem_q]) state_d = S_WR;
        else                     advance = 1'b1;
`else
        if (rd_mismatch)              state_d = S_DONE;
        else if (ELEM_HAS_WR[elem_q]) state_d = S_WR;
        else                          advance = 1'b1;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // All ops for the current address are complete: move to the next address or element.
    if (advance) begin
      if (ag_last) begin
        if (elem_q == M5) begin
          state_d = S_DONE;
          pass_d  = !fail_seen_d;
        end else begin
          elem_d     = elem_next;
          ag_load    = 1'b1;
          ag_load_up = ELEM_UP[elem_next];
          state_d    = ELEM_HAS_RD[elem_next] ? S_RD : S_WR;
        end
      end else begin
        ag_step = 1'b1;
        state_d = ELEM_HAS_RD[elem_q] ? S_RD : S_WR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= M0;
      cnt_q       <= '0;
      pass_q      <= 1'b0;
      fail_seen_q <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
`ifdef BIST_ERR_CNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      fail_seen_q <= fail_seen_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
`ifdef BIST_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign busy       = (state_q == S_WR) || (state_q == S_RD) ||
                      (state_q == S_RWAIT) || (state_q == S_CMP);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign fail_elem  = fail_elem_q;
  assign fail_addr  = fail_addr_q;
  assign fail_exp   = fail_exp_q;
  assign fail_act   = fail_act_q;
  assign ram_cs     = busy;
  assign ram_wr     = (state_q == S_WR);
  assign ram_out_en = (state_q == S_RD) || (state_q == S_RWAIT) || (state_q == S_CMP);
  assign ram_add    = ag_addr;
  assign ram_d_in   = (state_q == S_WR) ? wr_pat : '0;
`ifdef BIST_ERR_CNT_EN
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_ram_march_bist.sv
// tb/tb_ram_march_bist.sv - directed bench for ram_march_bist with behavioural RAM models
module tb_ram_march_bist;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start2;
  logic sa0_on, sa1_on;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic       busy1, done1, pass1, cs1, wr1, oe1;
  logic [2:0] fail_elem1;
  logic [4:0] fail_addr1, add1;
  logic [7:0] fail_exp1, fail_act1, d_in1, d_out1;
  logic       busy2, done2, pass2, cs2, wr2, oe2;
  logic [2:0] fail_elem2;
  logic [4:0] fail_addr2, add2;
  logic [7:0] fail_exp2, fail_act2, d_in2, d_out2;
`ifdef BIST_ERR_CNT_EN
  logic [7:0] err_cnt1, err_cnt2;
`endif

  ram_march_bist #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_elem(fail_elem1), .fail_addr(fail_addr1), .fail_exp(fail_exp1), .fail_act(fail_act1),
    .ram_cs(cs1), .ram_wr(wr1), .ram_out_en(oe1), .ram_add(add1), .ram_d_in(d_in1),
    .ram_d_out(d_out1)
`ifdef BIST_ERR_CNT_EN
    , .err_cnt(err_cnt1)
`endif
  );

  ram_march_bist #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_elem(fail_elem2), .fail_addr(fail_addr2), .fail_exp(fail_exp2), .fail_act(fail_act2),
    .ram_cs(cs2), .ram_wr(wr2), .ram_out_en(oe2), .ram_add(add2), .ram_d_in(d_in2),
    .ram_d_out(d_out2)
`ifdef BIST_ERR_CNT_EN
    , .err_cnt(err_cnt2)
`endif
  );

  logic [7:0] mem1 [0:31];
  logic [7:0] mem2 [0:31];
  logic [7:0] rd1_q, rd2_a, rd2_b;

  function automatic logic [7:0] ram1_read(input logic [4:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (sa0_on && a == 5'd5)  r[3] = 1'b0;
    if (sa1_on && a == 5'd31) r[0] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (cs1 && wr1) mem1[add1] <= d_in1;
    if (cs1 && oe1 && !wr1) rd1_q <= ram1_read(add1, mem1[add1]);
    if (cs2 && wr2) mem2[add2] <= d_in2;
    if (cs2 && oe2 && !wr2) rd2_a <= mem2[add2];
    rd2_b <= rd2_a;
  end
  assign d_out1 = rd1_q;
  assign d_out2 = rd2_b;

  task automatic run1(input int repulse_at, output int bcnt, output int dcnt, output bit tmo);
    bcnt = 0; dcnt = 0; tmo = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (busy1) bcnt++;
      if (done1) begin dcnt++; tmo = 1'b0; break; end
      start1 = (bcnt == repulse_at);
      @(negedge clk);
    end
    start1 = 1'b0;
    @(negedge clk); if (done1) dcnt++;
    @(negedge clk); if (done1) dcnt++;
  endtask

  task automatic test_reset();
    logic [47:0] o1, o2;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; sa0_on = 1'b0; sa1_on = 1'b0;
    repeat (3) @(negedge clk);
    o1 = {busy1, done1, pass1, fail_elem1, fail_addr1, fail_exp1, fail_act1, cs1, wr1, oe1, add1, d_in1};
    o2 = {busy2, done2, pass2, fail_elem2, fail_addr2, fail_exp2, fail_act2, cs2, wr2, oe2, add2, d_in2};
    total++; if (o1 !== 48'h0) begin bad++; $display("FAIL reset_outs1: got %h want 0", o1); end
    total++; if (o2 !== 48'h0) begin bad++; $display("FAIL reset_outs2: got %h want 0", o2); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    int bcnt, dcnt, nz;
    bit tmo;
    run1(-1, bcnt, dcnt, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL ff_timeout: got %0d want 0", tmo); end
    total++; if (bcnt !== 480) begin bad++; $display("FAIL ff_busy: got %0d want 480", bcnt); end
    total++; if (dcnt !== 1) begin bad++; $display("FAIL ff_done_pulses: got %0d want 1", dcnt); end
    total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL ff_pass: got %0d want 1", pass1); end
    nz = 0;
    for (int a = 0; a < 32; a++) if (mem1[a] !== 8'h00) nz++;
    total++; if (nz !== 0) begin bad++; $display("FAIL ff_ram_zero: got %0d nonzero want 0", nz); end
  endtask

  task automatic test_stuck0();
    int bcnt, dcnt;
    bit tmo;
    sa0_on = 1'b1;
    run1(-1, bcnt, dcnt, tmo);
    sa0_on = 1'b0;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL sa0_timeout: got %0d want 0", tmo); end
    total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL sa0_pass: got %0d want 0", pass1); end
    total++; if (fail_elem1 !== 3'd2) begin bad++; $display("FAIL sa0_elem: got %0d want 2", fail_elem1); end
    total++; if (fail_addr1 !== 5'd5) begin bad++; $display("FAIL sa0_addr: got %0d want 5", fail_addr1); end
    total++; if (fail_exp1 !== 8'hFF) begin bad++; $display("FAIL sa0_exp: got %h want ff", fail_exp1); end
    total++; if (fail_act1 !== 8'hF7) begin bad++; $display("FAIL sa0_act: got %h want f7", fail_act1); end
  endtask

  task automatic test_stuck1();
    int bcnt, dcnt;
    bit tmo;
    sa1_on = 1'b1;
    run1(-1, bcnt, dcnt, tmo);
    sa1_on = 1'b0;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL sa1_timeout: got %0d want 0", tmo); end
    total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL sa1_pass: got %0d want 0", pass1); end
    total++; if (fail_elem1 !== 3'd1) begin bad++; $display("FAIL sa1_elem: got %0d want 1", fail_elem1); end
    total++; if (fail_addr1 !== 5'd31) begin bad++; $display("FAIL sa1_addr: got %0d want 31", fail_addr1); end
    total++; if (fail_exp1 !== 8'h00) begin bad++; $display("FAIL sa1_exp: got %h want 00", fail_exp1); end
    total++; if (fail_act1 !== 8'h01) begin bad++; $display("FAIL sa1_act: got %h want 01", fail_act1); end
  endtask

  task automatic test_restart_ignored();
    int bcnt, dcnt;
    bit tmo;
    run1(100, bcnt, dcnt, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rs_timeout: got %0d want 0", tmo); end
    total++; if (bcnt !== 480) begin bad++; $display("FAIL rs_busy: got %0d want 480", bcnt); end
    total++; if (dcnt !== 1) begin bad++; $display("FAIL rs_done_pulses: got %0d want 1", dcnt); end
    total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL rs_pass: got %0d want 1", pass1); end
  endtask

  task automatic test_reset_mid();
    int bcnt, dcnt;
    bit tmo;
    logic [47:0] o1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (250) @(negedge clk);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %0d want 1", busy1); end
    rst_n = 1'b0;
    @(negedge clk);
    o1 = {busy1, done1, pass1, fail_elem1, fail_addr1, fail_exp1, fail_act1, cs1, wr1, oe1, add1, d_in1};
    total++; if (o1 !== 48'h0) begin bad++; $display("FAIL mid_reset_outs: got %h want 0", o1); end
    rst_n = 1'b1;
    @(negedge clk);
    run1(-1, bcnt, dcnt, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL mid_timeout: got %0d want 0", tmo); end
    total++; if (bcnt !== 480) begin bad++; $display("FAIL mid_busy: got %0d want 480", bcnt); end
    total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL mid_pass: got %0d want 1", pass1); end
  endtask

`ifdef BIST_ERR_CNT_EN
  task automatic test_err_cnt();
    int bcnt, dcnt;
    bit tmo;
    sa0_on = 1'b1; sa1_on = 1'b1;
    run1(-1, bcnt, dcnt, tmo);
    sa0_on = 1'b0; sa1_on = 1'b0;
    total++; if (bcnt !== 480) begin bad++; $display("FAIL ec_busy: got %0d want 480", bcnt); end
    total++; if (err_cnt1 !== 8'd5) begin bad++; $display("FAIL ec_count: got %0d want 5", err_cnt1); end
    total++; if (fail_elem1 !== 3'd1) begin bad++; $display("FAIL ec_elem: got %0d want 1", fail_elem1); end
    total++; if (fail_addr1 !== 5'd31) begin bad++; $display("FAIL ec_addr: got %0d want 31", fail_addr1); end
    total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL ec_pass: got %0d want 0", pass1); end
  endtask
`endif

  task automatic test_rd_lat2();
    int bcnt, oecnt, wrcnt;
    bit tmo;
    bcnt = 0; oecnt = 0; wrcnt = 0; tmo = 1'b1;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (busy2) bcnt++;
      if (oe2) oecnt++;
      if (wr2) wrcnt++;
      if (done2) begin tmo = 1'b0; break; end
      @(negedge clk);
    end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL l2_timeout: got %0d want 0", tmo); end
    total++; if (bcnt !== 640) begin bad++; $display("FAIL l2_busy: got %0d want 640", bcnt); end
    total++; if (oecnt !== 480) begin bad++; $display("FAIL l2_out_en_cycles: got %0d want 480", oecnt); end
    total++; if (wrcnt !== 160) begin bad++; $display("FAIL l2_wr_cycles: got %0d want 160", wrcnt); end
    total++; if (pass2 !== 1'b1) begin bad++; $display("FAIL l2_pass: got %0d want 1", pass2); end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck0();
    test_stuck1();
    test_restart_ignored();
    test_reset_mid();
`ifdef BIST_ERR_CNT_EN
    test_err_cnt();
`endif
    test_rd_lat2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
